// File: rtl/ase_umsg_scheduler.sv
// UMsg scheduler: per-slot hint/data delay FSMs feeding one round-robin
// arbitrated Rx0 UMsg pulse output.
module ase_umsg_scheduler #(
    parameter int NUM_UMSG    = 8,
    parameter int TIMER_WIDTH = 8,
    parameter int HINT_DELAY  = 4,
    parameter int DATA_DELAY  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                umsg_req_valid,
    input  logic [2:0]          umsg_req_id,
    input  logic [NUM_UMSG-1:0] umsg_hint_mask,
    input  logic                rx_ready,
    output logic                rx_umsg_valid,
    output logic                rx_umsg_type,
    output logic [5:0]          rx_umsg_id,
    output logic [NUM_UMSG-1:0] umsg_busy
);

    localparam int PTR_W = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1;
    localparam logic [TIMER_WIDTH-1:0] HINT_RELOAD = TIMER_WIDTH'(HINT_DELAY - 1);
    localparam logic [TIMER_WIDTH-1:0] DATA_RELOAD = TIMER_WIDTH'(DATA_DELAY - 1);

    typedef enum logic [2:0] {
        UMSG_IDLE,
        UMSG_HINT_WAIT,
        UMSG_SEND_HINT,
        UMSG_DATA_WAIT,
        UMSG_SEND_DATA
    } umsg_state_t;

    umsg_state_t            state_q [NUM_UMSG];
    umsg_state_t            state_d [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] timer_q [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] timer_d [NUM_UMSG];
    logic [NUM_UMSG-1:0]    req_hit;
    logic [NUM_UMSG-1:0]    gnt_hit;
    logic [PTR_W-1:0]       rr_ptr;
    logic                   grant_valid;
    logic [PTR_W-1:0]       grant_id;

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        return PTR_W'((32'(base) + off) % NUM_UMSG);
    endfunction

    // Round-robin search starting at rr_ptr; first eligible slot wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < NUM_UMSG; i++) begin
            if (rx_ready && !grant_valid &&
                (state_q[rr_index(rr_ptr, i)] == UMSG_SEND_HINT ||
                 state_q[rr_index(rr_ptr, i)] == UMSG_SEND_DATA)) begin
                grant_valid = 1'b1;
                grant_id    = rr_index(rr_ptr, i);
            end
        end
    end

    always_comb begin
        req_hit = '0;
        gnt_hit = '0;
        for (int unsigned i = 0; i < NUM_UMSG; i++) begin
            req_hit[i] = umsg_req_valid && (32'(umsg_req_id) == i);
            gnt_hit[i] = grant_valid && (32'(grant_id) == i);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_UMSG; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                UMSG_IDLE: begin
                    if (req_hit[i]) begin
                        if (umsg_hint_mask[i]) begin
                            state_d[i] = UMSG_HINT_WAIT;
                            timer_d[i] = HINT_RELOAD;
                        end else begin
                            state_d[i] = UMSG_DATA_WAIT;
                            timer_d[i] = DATA_RELOAD;
                        end
                    end
                end
                UMSG_HINT_WAIT: begin
                    if (timer_q[i] == '0) state_d[i] = UMSG_SEND_HINT;
                    else                  timer_d[i] = timer_q[i] - 1'b1;
                end
                UMSG_SEND_HINT: begin
                    if (gnt_hit[i]) begin
                        state_d[i] = UMSG_DATA_WAIT;
                        timer_d[i] = DATA_RELOAD;
                    end
                end
                UMSG_DATA_WAIT: begin
                    // A new write restarts the data deadline, even on the expiry edge.
                    if (req_hit[i])            timer_d[i] = DATA_RELOAD;
                    else if (timer_q[i] == '0) state_d[i] = UMSG_SEND_DATA;
                    else                       timer_d[i] = timer_q[i] - 1'b1;
                end
                UMSG_SEND_DATA: begin
                    if (gnt_hit[i]) begin
                        if (req_hit[i]) begin
                            state_d[i] = UMSG_DATA_WAIT;
                            timer_d[i] = DATA_RELOAD;
                        end else begin
                            state_d[i] = UMSG_IDLE;
                        end
                    end
                end
                default: begin
                    state_d[i] = UMSG_IDLE;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_UMSG; i++) begin
                state_q[i] <= UMSG_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_UMSG; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            rx_umsg_valid <= 1'b0;
            rx_umsg_type  <= 1'b0;
            rx_umsg_id    <= '0;
        end else begin
            rx_umsg_valid <= grant_valid;
            if (grant_valid) begin
                rr_ptr       <= rr_index(grant_id, 1);
                rx_umsg_type <= (state_q[grant_id] == UMSG_SEND_HINT);
                rx_umsg_id   <= 6'(grant_id);
            end
        end
    end

    always_comb begin
        umsg_busy = '0;
        for (int unsigned i = 0; i < NUM_UMSG; i++) begin
            umsg_busy[i] = (state_q[i] != UMSG_IDLE);
        end
    end

endmodule

// File: tb/tb_ase_umsg_scheduler.sv
// Bench for ase_umsg_scheduler: directed scenarios plus random traffic, all
// checked against a timestamp-based model of when each slot becomes sendable.
module tb_ase_umsg_scheduler;

    localparam int N  = 8;
    localparam int HD = 4;
    localparam int DD = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         umsg_req_valid = 1'b0;
    logic [2:0]   umsg_req_id = '0;
    logic [N-1:0] umsg_hint_mask = '0;
    logic         rx_ready = 1'b0;
    logic         rx_umsg_valid;
    logic         rx_umsg_type;
    logic [5:0]   rx_umsg_id;
    logic [N-1:0] umsg_busy;

    ase_umsg_scheduler #(
        .NUM_UMSG(N),
        .TIMER_WIDTH(8),
        .HINT_DELAY(HD),
        .DATA_DELAY(DD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .umsg_req_valid(umsg_req_valid),
        .umsg_req_id(umsg_req_id),
        .umsg_hint_mask(umsg_hint_mask),
        .rx_ready(rx_ready),
        .rx_umsg_valid(rx_umsg_valid),
        .rx_umsg_type(rx_umsg_type),
        .rx_umsg_id(rx_umsg_id),
        .umsg_busy(umsg_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per slot, what is owed (0 none, 1 hint, 2 data) and the edge after
    // which it may be sent.
    int         m_kind  [N];
    int         m_ready [N];
    int         m_ptr;
    int         cyc;
    logic       m_valid;
    logic       m_type;
    logic [5:0] m_id;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            m_kind[s]  = 0;
            m_ready[s] = 0;
        end
        m_ptr   = 0;
        m_valid = 1'b0;
        m_type  = 1'b0;
        m_id    = '0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] id, input logic [N-1:0] mask,
                              input logic rdy);
        int g;
        int r;
        int t;
        int old_kind;
        t = cyc;
        g = -1;
        r = v ? int'(id) : -1;
        if (rdy) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (g < 0 && m_kind[s] != 0 && t > m_ready[s]) g = s;
            end
        end
        old_kind = (g >= 0) ? m_kind[g] : 0;
        for (int s = 0; s < N; s++) begin
            if (s == g) begin
                if (m_kind[s] == 1) begin
                    m_kind[s] = 2; m_ready[s] = t + DD;
                end else if (s == r) begin
                    m_ready[s] = t + DD;
                end else begin
                    m_kind[s] = 0;
                end
            end else if (s == r) begin
                if (m_kind[s] == 0) begin
                    m_kind[s]  = mask[s] ? 1 : 2;
                    m_ready[s] = t + (mask[s] ? HD : DD);
                end else if (m_kind[s] == 2 && t <= m_ready[s]) begin
                    m_ready[s] = t + DD;
                end
            end
        end
        m_valid = (g >= 0);
        if (g >= 0) begin
            m_type = (old_kind == 1);
            m_id   = 6'(g);
            m_ptr  = (g + 1) % N;
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eb;
        eb = '0;
        for (int s = 0; s < N; s++) eb[s] = (m_kind[s] != 0);
        check_eq("rx_out", {24'd0, rx_umsg_valid, rx_umsg_type, rx_umsg_id},
                 {24'd0, m_valid, m_type, m_id});
        check_eq("busy", 32'(umsg_busy), 32'(eb));
    endtask

    task automatic tick(input logic v, input logic [2:0] id, input logic [N-1:0] mask,
                        input logic rdy);
        umsg_req_valid = v;
        umsg_req_id    = id;
        umsg_hint_mask = mask;
        rx_ready       = rdy;
        @(posedge clk);
        model_step(v, id, mask, rdy);
        cyc++;
        #1;
        check_model();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, '0, rdy);
    endtask

    // Called #1 after an edge; asserts reset mid-cycle and releases after two edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_out", {24'd0, rx_umsg_valid, rx_umsg_type, rx_umsg_id}, 32'd0);
        check_eq("rst_busy", 32'(umsg_busy), 32'd0);
        umsg_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", {24'd0, rx_umsg_valid, rx_umsg_type, rx_umsg_id}, 32'd0);
        check_eq("reset_busy", 32'(umsg_busy), 32'd0);
        rst_n = 1'b1;

        // Hint path on slot 2
        tick(1'b1, 3'd2, 8'h04, 1'b1);
        idle(4, 1'b1);
        idle(1, 1'b1);
        check_eq("hint_pulse", {rx_umsg_valid, rx_umsg_type, rx_umsg_id}, {1'b1, 1'b1, 6'd2});
        idle(8, 1'b1);
        idle(1, 1'b1);
        check_eq("hint_data_pulse", {rx_umsg_valid, rx_umsg_type, rx_umsg_id}, {1'b1, 1'b0, 6'd2});
        check_eq("hint_busy_clear", 32'(umsg_busy[2]), 32'd0);
        idle(2, 1'b1);

        // No-hint path on slot 5
        tick(1'b1, 3'd5, 8'h00, 1'b1);
        idle(8, 1'b1);
        idle(1, 1'b1);
        check_eq("nohint_pulse", {rx_umsg_valid, rx_umsg_type, rx_umsg_id}, {1'b1, 1'b0, 6'd5});
        idle(2, 1'b1);

        // Contention: move pointer to 2 via a grant to slot 1, then stack 1/3/6
        tick(1'b1, 3'd1, 8'h00, 1'b1);
        idle(9, 1'b1);
        tick(1'b1, 3'd1, 8'h00, 1'b0);
        tick(1'b1, 3'd3, 8'h00, 1'b0);
        tick(1'b1, 3'd6, 8'h00, 1'b0);
        idle(10, 1'b0);
        check_eq("cont_busy", 32'(umsg_busy), 32'h4A);
        idle(1, 1'b1);
        check_eq("cont_first", {rx_umsg_valid, rx_umsg_id}, {1'b1, 6'd3});
        idle(1, 1'b1);
        check_eq("cont_second", {rx_umsg_valid, rx_umsg_id}, {1'b1, 6'd6});
        idle(1, 1'b1);
        check_eq("cont_third", {rx_umsg_valid, rx_umsg_id}, {1'b1, 6'd1});
        idle(2, 1'b1);

        // Backpressure: slot 0 parked in SendHint for 20 cycles
        tick(1'b1, 3'd0, 8'h01, 1'b0);
        idle(4, 1'b0);
        for (int i = 0; i < 20; i++) begin
            idle(1, 1'b0);
            check_eq("bp_stall", 32'(rx_umsg_valid), 32'd0);
        end
        idle(1, 1'b1);
        check_eq("bp_release", {rx_umsg_valid, rx_umsg_type, rx_umsg_id}, {1'b1, 1'b1, 6'd0});
        idle(12, 1'b1);

        // Re-arm on slot 4
        tick(1'b1, 3'd4, 8'h00, 1'b1);
        idle(4, 1'b1);
        tick(1'b1, 3'd4, 8'h00, 1'b1);
        idle(8, 1'b1);
        check_eq("rearm_none_early", 32'(rx_umsg_valid), 32'd0);
        tick(1'b1, 3'd4, 8'h00, 1'b1);
        check_eq("rearm_pulse1", {rx_umsg_valid, rx_umsg_type, rx_umsg_id}, {1'b1, 1'b0, 6'd4});
        idle(8, 1'b1);
        idle(1, 1'b1);
        check_eq("rearm_pulse2", {rx_umsg_valid, rx_umsg_type, rx_umsg_id}, {1'b1, 1'b0, 6'd4});
        idle(1, 1'b1);
        check_eq("rearm_idle", 32'(umsg_busy[4]), 32'd0);

        // Reset mid-flight, then silence
        tick(1'b1, 3'd2, 8'h04, 1'b1);
        idle(3, 1'b1);
        pulse_reset();
        for (int i = 0; i < 25; i++) begin
            idle(1, 1'b1);
            check_eq("post_rst_quiet", 32'(rx_umsg_valid), 32'd0);
        end

        // Request on the first edge after release
        tick(1'b1, 3'd6, 8'h00, 1'b1);
        pulse_reset();
        tick(1'b1, 3'd7, 8'h80, 1'b1);
        idle(4, 1'b1);
        idle(1, 1'b1);
        check_eq("rel_hint", {rx_umsg_valid, rx_umsg_type, rx_umsg_id}, {1'b1, 1'b1, 6'd7});
        idle(12, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 3) == 0, 3'($urandom), N'($urandom), ($urandom % 4) != 0);
        end
        idle(40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
